// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 encodings, FSM states and access helpers for the MEM stage
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_SB:   store_strobe = 4'b0001 << lane;
            F3_SH:   store_strobe = lane[1] ? 4'b1100 : 4'b0011;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            F3_SB:   store_data = {4{data[7:0]}};
            F3_SH:   store_data = {2{data[15:0]}};
            default: store_data = data;
        endcase
    endfunction

    // Halfword sizes share funct3[1:0] = 01 and word sizes 10 for loads and stores alike.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   is_misaligned = lane[0];
            2'b10:   is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            is_illegal = (f3 > F3_SW);
        else
            is_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects the addressed byte/half of a read word and extends it
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data-memory bus access, stall and load/store formatting
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_address_in,
    input  logic        reg_write_in,
    input  logic [1:0]  alu_or_load_or_pc_plus_four_in,
    input  logic [31:0] pc_plus_four_in,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_address_out,
    output logic [1:0]  alu_or_load_or_pc_plus_four_out,
    output logic [31:0] pc_plus_four_out,
    output logic        reg_write_out,
    output logic        stall_out,
    output logic        fault_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        abort_q, abort_d;
    logic [31:0] load_data_q, load_data_d;

    logic        is_store;
    logic        start;
    logic        access_bad;
    logic        start_ok;
    logic        start_bad;
    logic        req_timeout;
    logic [31:0] fmt_data;

    logic        stall_c;
    logic        req_c;
    logic        fault_c;
    logic        rw_c;

    assign is_store    = mem_write_in & ~mem_read_in;
    assign start       = valid_in & (mem_read_in | mem_write_in) & (state_q == IDLE);
    assign access_bad  = is_misaligned(funct3_in, alu_result_in[1:0]) | is_illegal(funct3_in, is_store);
    assign start_ok    = start & ~access_bad;
    assign start_bad   = start & access_bad;
    assign req_timeout = (cnt_q == TIMEOUT_LAST);

    load_formatter u_load_formatter (
        .rdata  (dmem_rdata),
        .funct3 (f3_q),
        .lane   (addr_q[1:0]),
        .result (fmt_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            abort_q     <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            abort_q     <= abort_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = REQ;
            REQ:     if (dmem_ready || req_timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at start so the bus sees stable values for the whole REQ phase.
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        abort_d     = abort_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cnt_d   = 16'd0;
                    abort_d = 1'b0;
                    addr_d  = alu_result_in;
                    we_d    = is_store;
                    f3_d    = funct3_in;
                    wstrb_d = is_store ? store_strobe(funct3_in, alu_result_in[1:0]) : 4'd0;
                    wdata_d = is_store ? store_data(funct3_in, store_data_in) : 32'd0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (dmem_ready)
                    load_data_d = fmt_data;
                else if (req_timeout)
                    abort_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_c = 1'b0;
        req_c   = 1'b0;
        fault_c = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = start_ok;
                fault_c = start_bad;
            end
            REQ: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
            end
            DONE:    fault_c = abort_q;
            default: ;
        endcase
        // DONE replays the held instruction once with stall released; only an abort blocks its write.
        if (state_q == DONE)
            rw_c = reg_write_in & valid_in & ~abort_q;
        else
            rw_c = reg_write_in & valid_in & ~stall_c & ~fault_c;
    end

    assign stall_out     = stall_c & resetn;
    assign dmem_req      = req_c & resetn;
    assign fault_out     = fault_c & resetn;
    assign reg_write_out = rw_c & resetn;

    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;

    assign read_data_out                   = load_data_q;
    assign alu_result_out                  = alu_result_in;
    assign rd_address_out                  = rd_address_in;
    assign alu_or_load_or_pc_plus_four_out = alu_or_load_or_pc_plus_four_in;
    assign pc_plus_four_out                = pc_plus_four_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_address_in;
    logic        reg_write_in;
    logic [1:0]  wb_sel_in;
    logic [31:0] pc_plus_four_in;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_address_out;
    logic [1:0]  wb_sel_out;
    logic [31:0] pc_plus_four_out;
    logic        reg_write_out;
    logic        stall_out;
    logic        fault_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int errors;
    int checks;

    int          n_stall;
    int          n_req;
    logic        completed;
    logic        req_stable;
    logic        rw_in_stall;
    logic        done_rw;
    logic        done_fault;
    logic [31:0] done_rdata;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk                             (clk),
        .resetn                          (resetn),
        .valid_in                        (valid_in),
        .mem_read_in                     (mem_read_in),
        .mem_write_in                    (mem_write_in),
        .funct3_in                       (funct3_in),
        .alu_result_in                   (alu_result_in),
        .store_data_in                   (store_data_in),
        .rd_address_in                   (rd_address_in),
        .reg_write_in                    (reg_write_in),
        .alu_or_load_or_pc_plus_four_in  (wb_sel_in),
        .pc_plus_four_in                 (pc_plus_four_in),
        .read_data_out                   (read_data_out),
        .alu_result_out                  (alu_result_out),
        .rd_address_out                  (rd_address_out),
        .alu_or_load_or_pc_plus_four_out (wb_sel_out),
        .pc_plus_four_out                (pc_plus_four_out),
        .reg_write_out                   (reg_write_out),
        .stall_out                       (stall_out),
        .fault_out                       (fault_out),
        .dmem_req                        (dmem_req),
        .dmem_we                         (dmem_we),
        .dmem_addr                       (dmem_addr),
        .dmem_wdata                      (dmem_wdata),
        .dmem_wstrb                      (dmem_wstrb),
        .dmem_ready                      (dmem_ready),
        .dmem_rdata                      (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_instr(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                             input logic [4:0] rdst);
        valid_in        = v;
        mem_read_in     = rd;
        mem_write_in    = wr;
        funct3_in       = f3;
        alu_result_in   = addr;
        store_data_in   = sdata;
        reg_write_in    = rw;
        rd_address_in   = rdst;
        wb_sel_in       = rd ? 2'd1 : 2'd0;
        pc_plus_four_in = addr ^ 32'h0000_0F04;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds the current instruction until stall drops; ready arrives on REQ cycle index 'delay' (-1 = never).
    task automatic run_mem(input int delay);
        n_stall     = 0;
        n_req       = 0;
        completed   = 1'b0;
        req_stable  = 1'b1;
        rw_in_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmem_req) begin
                if (n_req == 0) begin
                    req_addr  = dmem_addr;
                    req_we    = dmem_we;
                    req_wstrb = dmem_wstrb;
                    req_wdata = dmem_wdata;
                end else if (dmem_addr !== req_addr || dmem_we !== req_we ||
                             dmem_wstrb !== req_wstrb || dmem_wdata !== req_wdata) begin
                    req_stable = 1'b0;
                end
                dmem_ready = (n_req == delay);
                n_req++;
            end else begin
                dmem_ready = 1'b0;
            end
            if (stall_out) begin
                n_stall++;
                if (reg_write_out) rw_in_stall = 1'b1;
            end else begin
                done_rw    = reg_write_out;
                done_fault = fault_out;
                done_rdata = read_data_out;
                completed  = 1'b1;
                break;
            end
            @(posedge clk);
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 1'b1, 5'd3);
        #1;
        checks++;
        if (stall_out !== 1'b0 || dmem_req !== 1'b0 || fault_out !== 1'b0 || reg_write_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b req=%b fault=%b rw=%b, required all 0",
                     stall_out, dmem_req, fault_out, reg_write_out);
        end
        checks++;
        if (read_data_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_read_data: got %h, required 00000000", read_data_out);
        end
        set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic test_lb_immediate();
        next_cycle();
        dmem_rdata = 32'h80FF_1234;
        set_instr(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 1'b1, 5'd7);
        run_mem(0);
        checks++;
        if (!completed || n_stall != 2 || n_req != 1) begin
            errors++;
            $display("FAIL lb_latency: done=%b stall_cycles=%0d req_cycles=%0d, required 1/2/1",
                     completed, n_stall, n_req);
        end
        checks++;
        if (done_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_data: got %h, required ffffff80", done_rdata);
        end
        checks++;
        if (done_rw !== 1'b1 || rw_in_stall !== 1'b0 || done_fault !== 1'b0) begin
            errors++;
            $display("FAIL lb_regwrite: done_rw=%b rw_in_stall=%b fault=%b, required 1/0/0",
                     done_rw, rw_in_stall, done_fault);
        end
    endtask

    task automatic test_lhu_wait();
        next_cycle();
        set_instr(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'd0, 1'b1, 5'd8);
        run_mem(3);
        checks++;
        if (!completed || n_stall != 5 || n_req != 4) begin
            errors++;
            $display("FAIL lhu_latency: done=%b stall_cycles=%0d req_cycles=%0d, required 1/5/4",
                     completed, n_stall, n_req);
        end
        checks++;
        if (req_addr !== 32'h0000_1000 || req_stable !== 1'b1 || req_we !== 1'b0) begin
            errors++;
            $display("FAIL lhu_bus: addr=%h stable=%b we=%b, required 00001000/1/0",
                     req_addr, req_stable, req_we);
        end
        checks++;
        if (done_rdata !== 32'h0000_80FF || done_rw !== 1'b1) begin
            errors++;
            $display("FAIL lhu_data: got %h rw=%b, required 000080ff/1", done_rdata, done_rw);
        end
    endtask

    task automatic test_lh_sign();
        next_cycle();
        set_instr(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'd0, 1'b1, 5'd9);
        run_mem(1);
        checks++;
        if (!completed || done_rdata !== 32'hFFFF_80FF) begin
            errors++;
            $display("FAIL lh_data: done=%b got %h, required ffff80ff", completed, done_rdata);
        end
    endtask

    task automatic test_stores();
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0000_00AB, 1'b0, 5'd0);
        run_mem(0);
        checks++;
        if (!completed || req_we !== 1'b1 || req_wstrb !== 4'b0010 ||
            req_wdata !== 32'hABAB_ABAB || req_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL sb_bus: done=%b we=%b wstrb=%b wdata=%h addr=%h, required 1 0010 abababab 00002000",
                     completed, req_we, req_wstrb, req_wdata, req_addr);
        end
        checks++;
        if (done_rw !== 1'b0 || n_stall != 2) begin
            errors++;
            $display("FAIL sb_done: rw=%b stall_cycles=%0d, required 0/2", done_rw, n_stall);
        end
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 5'd0);
        run_mem(0);
        checks++;
        if (!completed || req_wstrb !== 4'b1100 || req_wdata !== 32'hBEEF_BEEF || req_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL sh_bus: done=%b wstrb=%b wdata=%h addr=%h, required 1100 beefbeef 00002000",
                     completed, req_wstrb, req_wdata, req_addr);
        end
    endtask

    task automatic test_faults();
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h5555_5555, 1'b1, 5'd0);
        #1;
        checks++;
        if (fault_out !== 1'b1 || dmem_req !== 1'b0 || stall_out !== 1'b0 || reg_write_out !== 1'b0) begin
            errors++;
            $display("FAIL sw_misaligned: fault=%b req=%b stall=%b rw=%b, required 1/0/0/0",
                     fault_out, dmem_req, stall_out, reg_write_out);
        end
        next_cycle();
        set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (fault_out !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL fault_one_cycle: fault=%b req=%b stall=%b, required 0/0/0",
                     fault_out, dmem_req, stall_out);
        end
        next_cycle();
        set_instr(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 1'b1, 5'd4);
        #1;
        checks++;
        if (fault_out !== 1'b1 || stall_out !== 1'b0 || reg_write_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_load: fault=%b stall=%b rw=%b, required 1/0/0",
                     fault_out, stall_out, reg_write_out);
        end
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (fault_out !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL illegal_store: fault=%b req=%b, required 1/0", fault_out, dmem_req);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 1'b1, 5'd10);
        run_mem(-1);
        checks++;
        if (!completed || n_req != 4 || n_stall != 5) begin
            errors++;
            $display("FAIL timeout_length: done=%b req_cycles=%0d stall_cycles=%0d, required 1/4/5",
                     completed, n_req, n_stall);
        end
        checks++;
        if (done_fault !== 1'b1 || done_rw !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: fault=%b rw=%b, required 1/0", done_fault, done_rw);
        end
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'd0, 1'b1, 5'd5);
        #1;
        checks++;
        if (stall_out !== 1'b0 || fault_out !== 1'b0 || reg_write_out !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: stall=%b fault=%b rw=%b req=%b, required 0/0/1/0",
                     stall_out, fault_out, reg_write_out, dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1, 5'd5);
        #1;
        checks++;
        if (stall_out !== 1'b0 || reg_write_out !== 1'b1 || rd_address_out !== 5'd5 ||
            alu_result_out !== 32'h0000_1234 || pc_plus_four_out !== 32'h0000_1D30 || wb_sel_out !== 2'd0) begin
            errors++;
            $display("FAIL add_passthrough: stall=%b rw=%b rd=%0d alu=%h pc4=%h sel=%0d, required 0 1 5 00001234 00001d30 0",
                     stall_out, reg_write_out, rd_address_out, alu_result_out, pc_plus_four_out, wb_sel_out);
        end
        next_cycle();
        dmem_rdata = 32'hDEAD_BEEF;
        set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 1'b1, 5'd6);
        run_mem(0);
        checks++;
        if (!completed || done_rdata !== 32'hDEAD_BEEF || n_stall != 2 || done_rw !== 1'b1) begin
            errors++;
            $display("FAIL lw_b2b: done=%b data=%h stall_cycles=%0d rw=%b, required 1 deadbeef 2 1",
                     completed, done_rdata, n_stall, done_rw);
        end
        next_cycle();
        set_instr(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'd0, 1'b1, 5'd5);
        #1;
        checks++;
        if (stall_out !== 1'b0 || reg_write_out !== 1'b1 || read_data_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL add_after_load: stall=%b rw=%b rdata=%h, required 0 1 deadbeef",
                     stall_out, reg_write_out, read_data_out);
        end
    endtask

    task automatic test_reset_mid_req();
        next_cycle();
        set_instr(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 1'b1, 5'd11);
        next_cycle();
        checks++;
        if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_setup: req=%b stall=%b, required 1/1", dmem_req, stall_out);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0 || reg_write_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_req: req=%b stall=%b rw=%b, required 0/0/0",
                     dmem_req, stall_out, reg_write_out);
        end
        next_cycle();
        set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
        resetn = 1'b1;
        next_cycle();
        checks++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0 || read_data_out !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_idle: req=%b stall=%b rdata=%h, required 0 0 00000000",
                     dmem_req, stall_out, read_data_out);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        resetn     = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        set_instr(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
        test_reset();
        test_lb_immediate();
        test_lhu_wait();
        test_lh_sign();
        test_stores();
        test_faults();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
